// File: rtl/reg_dump_uart_pkg.sv
// Shared definitions for the register dump reader: FSM encoding,
// UART framing constants and the frame byte selector.
package reg_dump_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_NEXT    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;
  localparam int   BYTES_PER_REG        = 5;
  localparam int   UART_BITS            = 10;   // start + 8 data + stop
  localparam int   DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200

  // Value byte for frame slot idx: slot 0 is the index byte (sent
  // directly), slots 1..4 are the captured value MSB first.
  function automatic logic [7:0] frame_byte(input logic [31:0] val,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd1:    b = val[31:24];
      3'd2:    b = val[23:16];
      3'd3:    b = val[15:8];
      3'd4:    b = val[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_uart_tx_byte.sv
// UART 8N1 byte transmitter. Owns bit timing only; the caller owns
// sequencing. Ready is also high during the last cycle of the stop bit
// so a waiting byte is taken with no idle gap between frames.
module uart_tx_byte
  import reg_dump_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic [7:0] Data,
  input  logic       Valid,
  output logic       Ready,
  output logic       Tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          r_active;
  logic [CW-1:0] r_clkcnt;
  logic [3:0]    r_bitcnt;
  logic [8:0]    r_shift;
  logic          r_tx;
  logic          w_last;

  assign w_last = r_active && (r_bitcnt == 4'(UART_BITS - 1)) &&
                  (r_clkcnt == CW'(CLKS_PER_BIT - 1));
  assign Ready  = !r_active || w_last;
  assign Tx     = r_tx;

  // Accept a byte, then walk start/data/stop bits at CLKS_PER_BIT each.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      r_active <= 1'b0;
      r_clkcnt <= '0;
      r_bitcnt <= '0;
      r_shift  <= '1;
      r_tx     <= STOP_BIT;
    end else if (Valid && Ready) begin
      r_active <= 1'b1;
      r_clkcnt <= '0;
      r_bitcnt <= '0;
      r_shift  <= {STOP_BIT, Data};
      r_tx     <= START_BIT;
    end else if (r_active) begin
      if (r_clkcnt == CW'(CLKS_PER_BIT - 1)) begin
        r_clkcnt <= '0;
        if (r_bitcnt == 4'(UART_BITS - 1)) begin
          r_active <= 1'b0;
          r_tx     <= STOP_BIT;
        end else begin
          r_tx     <= r_shift[0];
          r_shift  <= {STOP_BIT, r_shift[8:1]};
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end else begin
        r_clkcnt <= r_clkcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_dump_uart.sv
// Register dump reader: walks RegSel over 0..NUM_REGS-1, samples RegVal
// after READ_LAT settle cycles and sends a 5-byte frame per register
// (index, then value MSB first) over UART 8N1.
// Per register: READ_LAT SELECT + 1 CAPTURE + 50*CLKS_PER_BIT SEND + 1 NEXT
// cycles. The index byte is handed to the transmitter in CAPTURE, so SEND
// is exactly the 50 bit times. From the edge that accepts Start to the
// edge entering FINISH is NUM_REGS*(READ_LAT+2+50*CLKS_PER_BIT) cycles;
// counting the accepting IDLE cycle and the FINISH cycle the dump spans
// NUM_REGS*(READ_LAT+2+50*CLKS_PER_BIT)+2 cycles.
module reg_dump_uart
  import reg_dump_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int READ_LAT     = 2,
  parameter int NUM_REGS     = 32
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] RegVal,
  output logic [4:0]  RegSel,
  output logic        Tx,
  output logic        Busy,
  output logic        Done
);

  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_regsel;
  logic [LW-1:0] r_lat;
  logic [2:0]    r_sent;
  logic [31:0]   r_shadow;
  logic          w_valid;
  logic [7:0]    w_data;
  logic          w_tx_ready;
  logic          w_last_reg;

  assign w_last_reg = (r_regsel == 5'(NUM_REGS - 1));
  assign RegSel     = r_regsel;
  assign Busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign Done       = (r_state == S_FINISH);

  // State register.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and transmitter handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_data      = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_nxt = S_SELECT;
      end
      S_SELECT: begin
        if (r_lat == LW'(READ_LAT - 1)) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Transmitter is idle here; the index byte needs no RegVal.
        w_valid     = 1'b1;
        w_data      = {3'b000, r_regsel};
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_valid = (r_sent != 3'(BYTES_PER_REG));
        w_data  = frame_byte(r_shadow, r_sent);
        if (!w_valid && w_tx_ready) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_state_nxt = w_last_reg ? S_FINISH : S_SELECT;
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register index, settle counter, byte counter and value shadow.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      r_regsel <= '0;
      r_lat    <= '0;
      r_sent   <= '0;
      r_shadow <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_regsel <= '0;
          r_lat    <= '0;
        end
        S_SELECT: begin
          r_lat <= r_lat + 1'b1;
        end
        S_CAPTURE: begin
          r_shadow <= RegVal;
          r_sent   <= 3'd1;
          r_lat    <= '0;
        end
        S_SEND: begin
          if (w_valid && w_tx_ready) r_sent <= r_sent + 1'b1;
        end
        S_NEXT: begin
          r_regsel <= w_last_reg ? 5'd0 : r_regsel + 1'b1;
        end
        default: begin
          r_regsel <= '0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .CLOCK(CLOCK),
    .Reset(Reset),
    .Data (w_data),
    .Valid(w_valid),
    .Ready(w_tx_ready),
    .Tx   (Tx)
  );

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart with CLKS_PER_BIT=4, READ_LAT=2: a 32-register
// instance and a 1-register instance, each with its own serial decoder.
module tb_reg_dump_uart;

  localparam int CPB      = 4;
  localparam int RL       = 2;
  localparam int PER_REG  = RL + 2 + 50 * CPB;  // 204

  logic        CLOCK = 1'b0;
  logic        Reset;
  logic        Start, Start1;
  logic [31:0] RegVal, RegVal1;
  logic [4:0]  RegSel, RegSel1;
  logic        Tx, Tx1, Busy, Busy1, Done, Done1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rx1_q[$];
  int rx_err  = 0;
  int rx1_err = 0;

  logic arm7, ovr7;
  int   sel_viol = 0;
  int   sel1_nz  = 0;
  int   prev_sel = 0;

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  assign RegVal  = (ovr7 && RegSel == 5'd7) ? 32'hDEAD_BEEF
                                            : 32'h1000_0000 + {27'd0, RegSel};
  assign RegVal1 = 32'hA5C3_0F81;

  reg_dump_uart #(.CLKS_PER_BIT(CPB), .READ_LAT(RL), .NUM_REGS(32)) u_dut (
    .CLOCK(CLOCK), .Reset(Reset), .Start(Start), .RegVal(RegVal),
    .RegSel(RegSel), .Tx(Tx), .Busy(Busy), .Done(Done));

  reg_dump_uart #(.CLKS_PER_BIT(CPB), .READ_LAT(RL), .NUM_REGS(1)) u_dut1 (
    .CLOCK(CLOCK), .Reset(Reset), .Start(Start1), .RegVal(RegVal1),
    .RegSel(RegSel1), .Tx(Tx1), .Busy(Busy1), .Done(Done1));

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int which);
    return (which == 0) ? Tx : Tx1;
  endfunction

  // Serial decoder: samples each bit in its second cycle.
  task automatic rx_run(input int which);
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge CLOCK);
      if (tx_of(which) === 1'b0) begin
        @(negedge CLOCK);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLOCK);
          b[i] = tx_of(which);
        end
        repeat (CPB) @(negedge CLOCK);
        stp = tx_of(which);
        if (which == 0) begin
          rx_q.push_back(b);
          if (stp !== 1'b1) rx_err++;
        end else begin
          rx1_q.push_back(b);
          if (stp !== 1'b1) rx1_err++;
        end
      end
    end
  endtask

  initial rx_run(0);
  initial rx_run(1);

  // Change RegVal of register 7 in the cycle right after its capture.
  initial begin
    ovr7 = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (arm7 && Busy && RegSel == 5'd7 && !ovr7) begin
        repeat (3) @(posedge CLOCK);
        #1 ovr7 = 1'b1;
      end else if (RegSel != 5'd7) begin
        ovr7 = 1'b0;
      end
    end
  end

  // RegSel must only hold or step by one while busy; single-register
  // instance must never leave 0.
  always @(negedge CLOCK) begin
    if (Busy !== 1'b1) prev_sel = 0;
    else begin
      if (int'(RegSel) < prev_sel || int'(RegSel) > prev_sel + 1) sel_viol++;
      prev_sel = int'(RegSel);
    end
    if (RegSel1 !== 5'd0) sel1_nz++;
  end

  task automatic wait_done(input int which, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK);
      if (((which == 0) ? Done : Done1) === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    check(name, 64'(hit), 64'd1);
  endtask

  typedef struct {
    int          idx;
    logic [39:0] exp;
  } frame_vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_vec_t vecs[6];
    int c_acc, lo, hi, k, extra;
    logic [39:0] got;

    vecs[0] = '{0,  40'h00_1000_0000};
    vecs[1] = '{1,  40'h01_1000_0001};
    vecs[2] = '{5,  40'h05_1000_0005};
    vecs[3] = '{7,  40'h07_1000_0007};
    vecs[4] = '{16, 40'h10_1000_0010};
    vecs[5] = '{31, 40'h1F_1000_001F};

    Reset = 1'b0; Start = 1'b0; Start1 = 1'b0; arm7 = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("rst_tx",     64'(Tx),      64'd1);
    check("rst_regsel", 64'(RegSel),  64'd0);
    check("rst_busy",   64'(Busy),    64'd0);
    check("rst_done",   64'(Done),    64'd0);
    check("rst_tx1",    64'(Tx1),     64'd1);
    check("rst_busy1",  64'(Busy1),   64'd0);
    Reset = 1'b1;
    repeat (2) @(negedge CLOCK);

    // Full dump with a one-cycle Start pulse.
    arm7 = 1'b1;
    Start = 1'b1;
    @(negedge CLOCK);
    Start = 1'b0;
    c_acc = cyc;
    check("accept_busy",   64'(Busy),   64'd1);
    check("accept_regsel", 64'(RegSel), 64'd0);
    k = 0;
    while (Tx !== 1'b0 && k < 20) begin @(negedge CLOCK); k++; end
    check("first_start_seen", 64'(k < 20), 64'd1);
    lo = 0;
    while (Tx === 1'b0 && lo < 100) begin lo++; @(negedge CLOCK); end
    check("byte0_low_cycles", 64'(lo), 64'd36);
    hi = 0;
    while (Tx === 1'b1 && hi < 100) begin hi++; @(negedge CLOCK); end
    check("byte0_stop_cycles", 64'(hi), 64'd4);
    wait_done(0, 7000, "dump_done_seen");
    check("dump_length",    64'(cyc - c_acc), 64'(32 * PER_REG));
    check("done_busy_low",  64'(Busy),   64'd0);
    check("done_regsel",    64'(RegSel), 64'd0);
    @(negedge CLOCK);
    check("done_one_cycle", 64'(Done),   64'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      if (Done === 1'b1) extra++;
    end
    check("done_no_repeat", 64'(extra), 64'd0);
    check("rx_byte_count",  64'(rx_q.size()), 64'd160);
    check("rx_framing",     64'(rx_err), 64'd0);
    if (rx_q.size() == 160) begin
      foreach (vecs[v]) begin
        k = vecs[v].idx * 5;
        got = {rx_q[k], rx_q[k+1], rx_q[k+2], rx_q[k+3], rx_q[k+4]};
        check($sformatf("frame_tbl_%0d", vecs[v].idx), 64'(got), 64'(vecs[v].exp));
      end
      for (int r = 0; r < 32; r++) begin
        got = {rx_q[5*r], rx_q[5*r+1], rx_q[5*r+2], rx_q[5*r+3], rx_q[5*r+4]};
        check($sformatf("frame_%0d", r), 64'(got),
              64'({8'(r), 32'h1000_0000 + 32'(r)}));
      end
    end
    arm7 = 1'b0;

    // Reset mid-SEND on register 3.
    rx_q.delete();
    Start = 1'b1;
    @(negedge CLOCK);
    Start = 1'b0;
    k = 0;
    while (RegSel !== 5'd3 && k < 1000) begin @(negedge CLOCK); k++; end
    check("reach_reg3", 64'(k < 1000), 64'd1);
    k = 0;
    while (Tx !== 1'b0 && k < 20) begin @(negedge CLOCK); k++; end
    @(negedge CLOCK);
    check("reg3_tx_low", 64'(Tx), 64'd0);
    #2 Reset = 1'b0;
    #1;
    check("abort_tx",     64'(Tx),     64'd1);
    check("abort_regsel", 64'(RegSel), 64'd0);
    check("abort_busy",   64'(Busy),   64'd0);
    check("abort_done",   64'(Done),   64'd0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      if (Done === 1'b1) extra++;
    end
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      if (Done === 1'b1 || Busy === 1'b1) extra++;
    end
    check("abort_stays_idle", 64'(extra), 64'd0);
    check("abort_idle_tx",    64'(Tx),    64'd1);
    repeat (60) @(negedge CLOCK);
    rx_q.delete();
    rx_err = 0;

    // Start held high through a whole dump.
    Start = 1'b1;
    @(negedge CLOCK);
    c_acc = cyc;
    check("held_busy", 64'(Busy), 64'd1);
    wait_done(0, 7000, "held_done_seen");
    check("held_length",    64'(cyc - c_acc), 64'(32 * PER_REG));
    check("held_done_busy", 64'(Busy),   64'd0);
    check("held_rx_count",  64'(rx_q.size()), 64'd160);
    @(negedge CLOCK);
    check("held_idle_busy", 64'(Busy), 64'd0);
    @(negedge CLOCK);
    check("held_restart_busy",   64'(Busy),   64'd1);
    check("held_restart_regsel", 64'(RegSel), 64'd0);
    check("regsel_monotonic",    64'(sel_viol), 64'd0);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge CLOCK);
    Reset = 1'b1;
    repeat (60) @(negedge CLOCK);
    rx_q.delete();

    // Single-register instance.
    Start1 = 1'b1;
    @(negedge CLOCK);
    Start1 = 1'b0;
    c_acc = cyc;
    check("n1_busy", 64'(Busy1), 64'd1);
    wait_done(1, 400, "n1_done_seen");
    check("n1_length",    64'(cyc - c_acc), 64'(PER_REG));
    check("n1_done_busy", 64'(Busy1), 64'd0);
    check("n1_rx_count",  64'(rx1_q.size()), 64'd5);
    if (rx1_q.size() == 5) begin
      got = {rx1_q[0], rx1_q[1], rx1_q[2], rx1_q[3], rx1_q[4]};
      check("n1_frame", 64'(got), 64'h00_A5C3_0F81);
    end
    check("n1_framing",   64'(rx1_err), 64'd0);
    check("n1_regsel_0",  64'(sel1_nz), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/reg_dump_uart.md
Name: reg_dump_uart

Overview:
- Debug reader for the processor's register-inspection port.
- Drives the register-select index (Regin side) and samples the selected register value (Regout side).
- Walks registers 0..NUM_REGS-1 on request and streams each one out over a UART 8N1 transmit line.
- Sits in the top level beside the Uniciclo core, clocked by the board clock, and gives the team a register dump on a host terminal.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
- READ_LAT, 2, settle cycles between driving RegSel and sampling RegVal; minimum 1.
- NUM_REGS, 32, registers dumped; range 1..32.

Ports:
- CLOCK  in  1  single clock for the whole block.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  dump request, level-sampled in IDLE.
- RegVal  in  32  value of the selected register (the core's regout).
- RegSel  out  5  register index to the core's regin.
- Tx  out  1  UART serial output; idle high.
- Busy  out  1  high from dump accept until the last stop bit ends; the system may use it as a CPU halt request.
- Done  out  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (Reset=0, async):
  - Tx=1, RegSel=0, Busy=0, Done=0.
  - FSM goes to IDLE, all counters cleared.
  - Reset during a transfer aborts it immediately; the partial frame on Tx is truncated high.
- FSM states: IDLE, SELECT, CAPTURE, SEND, NEXT, FINISH.
- IDLE:
  - Start=1 at edge t -> Busy=1 and RegSel=0 from t+1; go to SELECT.
  - Start while Busy is ignored (no queueing).
- SELECT:
  - Hold RegSel for READ_LAT cycles, then go to CAPTURE.
- CAPTURE:
  - One cycle: latch RegVal into a 32-bit shadow register.
  - Load the 5-byte frame: index byte {3'b000,RegSel}, then value bytes MSB first (b31..24, b23..16, b15..8, b7..0).
  - Go to SEND.
- SEND:
  - Hand bytes one at a time to the byte transmitter (valid/ready handshake).
  - After the 5th byte's stop bit completes, go to NEXT.
  - RegSel is held stable for the whole SEND period.
  - RegVal changes after CAPTURE do not affect the frame.
- NEXT:
  - If RegSel == NUM_REGS-1, go to FINISH.
  - Otherwise RegSel increments by 1 and the FSM returns to SELECT.
  - No wrap past NUM_REGS-1.
- FINISH:
  - Done=1 for exactly one cycle, Busy=0 in the same cycle, RegSel returns to 0, then go to IDLE.
  - Start=1 during the FINISH cycle is ignored. A Start still high in the following IDLE cycle starts a new dump.
- UART byte format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bytes go back-to-back with no extra idle time between them.
- Dump length: NUM_REGS*(READ_LAT + 1 + 50*CLKS_PER_BIT + 1) + 2 cycles from Start acceptance to Done, ±1 cycle of handshake overhead. The implementation must document its exact constant.
- Register x0 is dumped like any other register; it carries whatever value the core presents, nominally 0.

Decomposition:
- Shared package/include (Parametros.v style):
  - FSM state encodings.
  - UART frame constants: START_BIT=0, STOP_BIT=1, BYTES_PER_REG=5.
  - Default CLKS_PER_BIT.
- Sub-module uart_tx_byte (CLKS_PER_BIT parameter):
  - Ports: CLOCK, Reset, Data[7:0], Valid, Ready, Tx.
  - Ready=1 while idle. Valid&Ready accepts the byte and drops Ready until its stop bit ends.
  - The top FSM owns the sequencing; the sub-module owns the bit timing.

Test Plan (CLKS_PER_BIT=4, READ_LAT=2):
- Reset low mid-SEND on register 3 -> Tx=1, RegSel=0, Busy=0 within the same cycle (async); no Done; FSM idle after release.
- Start pulse with RegVal model returning 32'h1000_0000+idx -> Rx decoder sees 32 frames; frame 5 is 05 10 00 00 05; Done pulses once; Busy falls with Done.
- Bit timing on the first byte (00) -> Tx low for 9 bits = 36 cycles, then high for 4 cycles; next start bit begins immediately after.
- RegVal changed to 32'hDEADBEEF one cycle after CAPTURE for register 7 -> frame 7 still carries the pre-change value.
- Start held high through the whole dump -> no re-trigger while Busy; the second dump begins in the first IDLE cycle after FINISH; RegSel restarts at 0.
- NUM_REGS=1 instance -> exactly one frame (00 + 4 data bytes), then Done; RegSel never leaves 0.
